// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // All-ones pattern of w bits, right-aligned in a 64-bit word (w <= 64).
    function automatic logic [63:0] div_zero_quot(input int w);
        div_zero_quot = {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// pull in the next dividend bit and trial-subtract the divisor magnitude.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted
    // value fits WIDTH+1 bits and the top bit of the difference is its sign.
    assign w_shifted = {i_rem, i_msb};
    assign w_diff    = w_shifted - {1'b0, i_dvs};
    assign o_qbit    = ~w_diff[WIDTH];
    assign o_rem     = o_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Optional signed support is compiled in with `define SEQ_DIV_SIGNED_EN;
// without it signed_i is ignored and every division is unsigned.
//
// Handshake: start_i is sampled on a rising edge whenever the block is not
// busy (IDLE or DONE). busy_o is high while iterating and start_i is ignored
// then. done_o pulses for one cycle when quotient_o/remainder_o/div_zero_o
// become valid; those outputs hold until the next accepted start.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [63:0]      ZQ_FULL   = div_zero_quot(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_QUOT = ZQ_FULL[WIDTH-1:0];

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dividend;
    logic             r_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_next_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    assign w_accept = start_i && (r_state != ST_BUSY);
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
    assign w_q_mag  = {r_work[WIDTH-2:0], w_qbit};

`ifdef SEQ_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign w_dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend_i : dividend_i;
    assign w_dvs_mag = w_dvs_neg ? -divisor_i : divisor_i;
    // Truncating division: quotient sign from both operands, remainder
    // follows the dividend. MIN/-1 wraps back to MIN naturally.
    assign w_q_fin   = r_neg_q ? -w_q_mag : w_q_mag;
    assign w_r_fin   = r_neg_r ? -w_next_rem : w_next_rem;

    // Sign flags captured alongside the operands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_i;
    assign w_dvd_mag       = dividend_i;
    assign w_dvs_mag       = divisor_i;
    assign w_q_fin         = w_q_mag;
    assign w_r_fin         = w_next_rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_work[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_next_rem),
        .o_qbit (w_qbit)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. A zero divisor takes a single pass through BUSY
    // (counter loaded with 1) so its result lands one edge after acceptance.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_next_state = ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(1)) w_next_state = ST_DONE;
            ST_DONE: w_next_state = start_i ? ST_BUSY : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, shift-subtract iteration and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_work      <= '0;
            r_dvs       <= '0;
            r_dividend  <= '0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_rem      <= '0;
            r_work     <= w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_dividend <= dividend_i;
            r_zero     <= (divisor_i == '0);
            r_cnt      <= (divisor_i == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
            r_div_zero <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            r_rem  <= w_next_rem;
            r_work <= w_q_mag;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (w_last) begin
                if (r_zero) begin
                    r_quotient  <= ZERO_QUOT;
                    r_remainder <= r_dividend;
                    r_div_zero  <= 1'b1;
                end else begin
                    r_quotient  <= w_q_fin;
                    r_remainder <= w_r_fin;
                    r_div_zero  <= 1'b0;
                end
            end
        end
    end

    assign busy_o      = (r_state == ST_BUSY);
    assign done_o      = (r_state == ST_DONE);
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_div_zero;

endmodule
